layer_mac: RTL and testbench
============================

// Module: layer_mac
// PURPOSE
//  Weighted-sum engine feeding the Sigmoid activation stage of one FCNN layer.
//  - Streams NoInputs activations one per handshake and multiplies each by a column of NoNeurons weights.
//  - Accumulates one sum per neuron.
//  - Presents NoNeurons fixed-point sums as oData, held until taken downstream.
//  Producer side of the Sigmoid iData interface; biases are added downstream.
// PARAMETERS
//  dataWidth  16   signed fixed-point width of iData, weights and oData
//  fracBits   8    fractional bits (Q(dataWidth-fracBits).fracBits)
//  NoInputs   784  activations per inference (previous layer size)
//  NoNeurons  30   neurons in this layer
// PORTS
//  clk        in   1                        clock, all state on rising edge
//  rst        in   1                        asynchronous, active-low reset
//  start      in   1                        begin new inference (IDLE only)
//  iValid     in   1                        iData/weights valid
//  iReady     out  1                        engine accepts input this cycle
//  iData      in   dataWidth                signed activation
//  weights    in   NoNeurons x dataWidth    signed weight column for current input
//  weightAddr out  $clog2(NoInputs)         index of the input expected next (weight ROM address)
//  oValid     out  1                        oData holds a complete result
//  oReady     in   1                        downstream takes oData
//  oData      out  NoNeurons x dataWidth    signed sums, Q format as iData
//  busy       out  1                        state != IDLE
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE, cnt=0, accumulators=0.
//    Outputs: iReady=0, oValid=0, oData=0, busy=0, weightAddr=0.
//  - FSM IDLE -> ACCUM -> OUT -> IDLE.
//    IDLE: start=1 clears accumulators and cnt; next state ACCUM. start ignored in other states.
//    ACCUM: iReady=1. Accept = iValid & iReady; weights sampled in the same cycle as iData.
//      Per accept: acc[i] += iData*weights[i] (full 2*dataWidth signed product); cnt++.
//      Accept with cnt==NoInputs-1 -> OUT; cnt wraps to 0.
//      Cycles with iValid=0 change nothing.
//    OUT: iReady=0; oValid=1 from the cycle after the last accept (latency 1).
//      oData[i] = acc[i] >>> fracBits (arithmetic), narrowed per SATURATE_EN.
//      oData stable while oValid=1 & oReady=0.
//      oValid & oReady -> IDLE, oValid=0 next cycle.
//  - Accumulator width 2*dataWidth+$clog2(NoInputs): never overflows internally.
//  - weightAddr = cnt.
//  - Reset mid-operation: partial sums discarded, no oValid; the next start runs clean.
// CONFIGURATION
//  SATURATE_EN defined:
//    narrowing clamps to [-2^(dataWidth-1), 2^(dataWidth-1)-1].
//  SATURATE_EN undefined:
//    narrowing keeps the low dataWidth bits (two's-complement wrap); no clamp logic built.
// TESTING  (NoInputs=4, NoNeurons=2, dataWidth=16, fracBits=8; 1.0=16'h0100)
//  1 Basic sum:
//    - stimulus: start; 4 inputs 16'h0100; all weights 16'h0080
//    - response: oValid 1 cycle after 4th accept; oData={16'h0200,16'h0200}
//  2 Input gaps:
//    - stimulus: same data as test 1, with iValid low 3 cycles between samples
//    - response: same oData; weightAddr steps 0,1,2,3 only on accepts
//  3 Backpressure:
//    - stimulus: oReady=0 for 5 cycles; start pulsed during OUT
//    - response: oData stable, iReady=0, start ignored; oReady=1 -> IDLE next cycle
//  4 Signed input:
//    - stimulus: inputs 16'hFF00 (-1.0); weights 16'h0100
//    - response: oData=16'hFC00 (-4.0) per neuron
//  5 Overflow:
//    - stimulus: inputs 16'h7F00; weights 16'h7F00
//    - response: SATURATE_EN -> 16'h7FFF; else 16'h0400 (low bits of 64516.0)
//  6 Reset in ACCUM:
//    - stimulus: rst=0 after 2 accepts
//    - response: oValid=0, busy=0 immediately; next run reproduces test 1 exactly

Source files
------------

// File: rtl/layer_mac.sv
// layer_mac: weighted-sum engine for one fully connected layer.
// Streams NoInputs activations, multiplies each by a column of NoNeurons
// weights, accumulates one sum per neuron and presents the fixed-point sums
// on oData until downstream takes them. Biases are added downstream.
// Optional feature macro: SATURATE_EN
//   defined   -> narrowing of each sum clamps to the signed dataWidth range
//   undefined -> narrowing keeps the low dataWidth bits (two's-complement wrap)
//
// state | meaning
// IDLE  | waiting for start, outputs quiet
// ACCUM | accepting activations, one accumulate per handshake
// OUT   | result presented on oData, waiting for oReady
module layer_mac #(
    parameter int dataWidth = 16,
    parameter int fracBits  = 8,
    parameter int NoInputs  = 784,
    parameter int NoNeurons = 30
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic                              iValid,
    output logic                              iReady,
    input  logic [dataWidth-1:0]              iData,
    input  logic [NoNeurons*dataWidth-1:0]    weights,
    output logic [$clog2(NoInputs)-1:0]       weightAddr,
    output logic                              oValid,
    input  logic                              oReady,
    output logic [NoNeurons*dataWidth-1:0]    oData,
    output logic                              busy
);

    localparam int AW   = $clog2(NoInputs);
    localparam int PW   = 2 * dataWidth;
    // Headroom of log2(NoInputs) bits means the running sum can never overflow.
    localparam int ACCW = PW + AW;
    localparam logic [AW-1:0] LAST = AW'(NoInputs - 1);

`ifdef SATURATE_EN
    localparam logic signed [ACCW-1:0] SAT_MAX = {{(ACCW-dataWidth+1){1'b0}}, {(dataWidth-1){1'b1}}};
    localparam logic signed [ACCW-1:0] SAT_MIN = {{(ACCW-dataWidth+1){1'b1}}, {(dataWidth-1){1'b0}}};
`endif

    typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;

    state_t                  state;
    logic [AW-1:0]           cnt;
    logic signed [ACCW-1:0]  acc     [NoNeurons];
    logic signed [ACCW-1:0]  acc_sum [NoNeurons];
    logic signed [PW-1:0]    prod    [NoNeurons];

    // Rescale a full-precision sum back to the input Q format.
    function automatic logic [dataWidth-1:0] narrow(input logic signed [ACCW-1:0] a);
        logic signed [ACCW-1:0] s;
        s = a >>> fracBits;
`ifdef SATURATE_EN
        if (s > SAT_MAX)
            narrow = SAT_MAX[dataWidth-1:0];
        else if (s < SAT_MIN)
            narrow = SAT_MIN[dataWidth-1:0];
        else
            narrow = s[dataWidth-1:0];
`else
        narrow = s[dataWidth-1:0];
`endif
    endfunction

    assign weightAddr = cnt;

    // Per-neuron product of the current activation and its weight, added to the running sum.
    always_comb begin
        for (int i = 0; i < NoNeurons; i++) begin
            prod[i]    = $signed(iData) * $signed(weights[i*dataWidth +: dataWidth]);
            acc_sum[i] = acc[i] + {{(ACCW-PW){prod[i][PW-1]}}, prod[i]};
        end
    end

    // Sequencer, accumulators and registered handshake outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= '0;
            iReady <= 1'b0;
            oValid <= 1'b0;
            busy   <= 1'b0;
            oData  <= '0;
            for (int i = 0; i < NoNeurons; i++)
                acc[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= ACCUM;
                        cnt    <= '0;
                        iReady <= 1'b1;
                        busy   <= 1'b1;
                        for (int i = 0; i < NoNeurons; i++)
                            acc[i] <= '0;
                    end
                end
                ACCUM: begin
                    if (iValid && iReady) begin
                        for (int i = 0; i < NoNeurons; i++)
                            acc[i] <= acc_sum[i];
                        if (cnt == LAST) begin
                            // Result is narrowed from the sum including this last sample.
                            state  <= OUT;
                            cnt    <= '0;
                            iReady <= 1'b0;
                            oValid <= 1'b1;
                            for (int i = 0; i < NoNeurons; i++)
                                oData[i*dataWidth +: dataWidth] <= narrow(acc_sum[i]);
                        end else begin
                            cnt <= cnt + AW'(1);
                        end
                    end
                end
                OUT: begin
                    if (oReady) begin
                        state  <= IDLE;
                        oValid <= 1'b0;
                        busy   <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    iReady <= 1'b0;
                    oValid <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_layer_mac.sv
// Testbench for layer_mac with NoInputs=4, NoNeurons=2, Q8.8 data.
module tb_layer_mac;

    localparam int DW = 16;
    localparam int NI = 4;
    localparam int NN = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           start = 1'b0;
    logic           iValid = 1'b0;
    logic           iReady;
    logic [DW-1:0]  iData = '0;
    logic [NN*DW-1:0] weights = '0;
    logic [1:0]     weightAddr;
    logic           oValid;
    logic           oReady = 1'b1;
    logic [NN*DW-1:0] oData;
    logic           busy;

    int checks = 0;
    int errors = 0;

    logic [NN*DW-1:0] exp_q[$];
    logic [DW-1:0]    cur_d [NI];
    logic [NN*DW-1:0] cur_w [NI];

    layer_mac #(.dataWidth(DW), .fracBits(8), .NoInputs(NI), .NoNeurons(NN)) dut (
        .clk(clk), .rst(rst), .start(start), .iValid(iValid), .iReady(iReady),
        .iData(iData), .weights(weights), .weightAddr(weightAddr), .oValid(oValid),
        .oReady(oReady), .oData(oData), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference: plain integer dot product, rescale, then clamp or wrap.
    function automatic logic [NN*DW-1:0] model();
        logic [NN*DW-1:0] r;
        r = '0;
        for (int n = 0; n < NN; n++) begin
            longint s;
            logic signed [DW-1:0] a, b;
            s = 0;
            for (int k = 0; k < NI; k++) begin
                a = cur_d[k];
                b = cur_w[k][n*DW +: DW];
                s += longint'(a) * longint'(b);
            end
            s = s / 256 - ((s % 256 != 0 && s < 0) ? 1 : 0);
`ifdef SATURATE_EN
            if (s > 32767) s = 32767;
            if (s < -32768) s = -32768;
`endif
            r[n*DW +: DW] = s[DW-1:0];
        end
        return r;
    endfunction

    // Monitor: compare each newly presented result against the scoreboard.
    initial begin
        logic seen;
        logic [NN*DW-1:0] e;
        seen = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst || !oValid) begin
                seen = 1'b0;
            end else if (!seen) begin
                seen = 1'b1;
                if (exp_q.size() == 0) begin
                    check("unexpected_oValid", 64'(oValid), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("sb_oData", 64'(oData), 64'(e));
                end
            end
        end
    end

    task automatic do_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic feed(input int k, input int gap);
        for (int g = 0; g < gap; g++) begin
            iValid = 1'b0;
            @(posedge clk); #1;
            check("addr_gap", 64'(weightAddr), 64'(k));
        end
        iData = cur_d[k];
        weights = cur_w[k];
        iValid = 1'b1;
        check("addr_accept", 64'(weightAddr), 64'(k));
        @(posedge clk); #1;
        iValid = 1'b0;
    endtask

    task automatic run(input int gap, input int hold, input bit pulse);
        logic [NN*DW-1:0] e;
        e = model();
        exp_q.push_back(e);
        oReady = (hold == 0);
        do_start();
        check("iReady_accum", 64'(iReady), 64'(1));
        for (int k = 0; k < NI; k++) feed(k, gap);
        check("latency_oValid", 64'(oValid), 64'(1));
        check("iReady_out", 64'(iReady), 64'(0));
        for (int h = 0; h < hold; h++) begin
            start = (pulse && h == 1);
            @(posedge clk); #1;
            start = 1'b0;
            check("hold_oValid", 64'(oValid), 64'(1));
            check("hold_oData", 64'(oData), 64'(e));
            check("hold_iReady", 64'(iReady), 64'(0));
        end
        oReady = 1'b1;
        @(posedge clk); #1;
        check("taken_oValid", 64'(oValid), 64'(0));
        check("taken_busy", 64'(busy), 64'(0));
        if (pulse) begin
            @(posedge clk); #1;
            check("start_ignored_iReady", 64'(iReady), 64'(0));
            check("start_ignored_busy", 64'(busy), 64'(0));
        end
    endtask

    task automatic fill(input logic [DW-1:0] d, input logic [DW-1:0] w);
        for (int k = 0; k < NI; k++) begin
            cur_d[k] = d;
            cur_w[k] = {w, w};
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        #3;
        check("rst_iReady", 64'(iReady), 64'(0));
        check("rst_oValid", 64'(oValid), 64'(0));
        check("rst_oData", 64'(oData), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_addr", 64'(weightAddr), 64'(0));
        @(posedge clk); #1 rst = 1'b1;

        // basic sum
        fill(16'h0100, 16'h0080);
        run(0, 0, 1'b0);
        check("basic_oData", 64'(oData), 64'h0200_0200);

        // input gaps
        run(3, 0, 1'b0);
        check("gaps_oData", 64'(oData), 64'h0200_0200);

        // backpressure with start pulsed during OUT
        run(0, 5, 1'b1);

        // signed input
        fill(16'hFF00, 16'h0100);
        run(1, 0, 1'b0);
        check("signed_oData", 64'(oData), 64'hFC00_FC00);

        // overflow of the narrowed result
        fill(16'h7F00, 16'h7F00);
        run(0, 0, 1'b0);
`ifdef SATURATE_EN
        check("overflow_oData", 64'(oData), 64'h7FFF_7FFF);
`else
        check("overflow_oData", 64'(oData), 64'h0400_0400);
`endif

        // reset after two accepts
        fill(16'h0100, 16'h0080);
        do_start();
        feed(0, 0);
        feed(1, 0);
        #2 rst = 1'b0;
        #1;
        check("midrst_oValid", 64'(oValid), 64'(0));
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_iReady", 64'(iReady), 64'(0));
        @(posedge clk); #1 rst = 1'b1;
        run(0, 0, 1'b0);
        check("after_rst_oData", 64'(oData), 64'h0200_0200);

        // randomized runs
        for (int r = 0; r < 25; r++) begin
            for (int k = 0; k < NI; k++) begin
                cur_d[k] = DW'($urandom);
                cur_w[k] = {DW'($urandom), DW'($urandom)};
                if (r < 10) begin
                    cur_d[k] = DW'($signed(DW'($urandom_range(0, 1023))) - 512);
                end
            end
            run(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 1'b0);
        end

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
